// File: rtl/bench_td_rx.sv
// bench_td_rx: 8N1 serial receiver that packs BYTES bytes, LSB first, into one
// WORD_W-bit control word. The word is offered on a valid/ready handshake through a
// single holding register.
// Optional feature: define BENCH_RX_PARITY_EN to add an even-parity bit after the data.
// With the macro defined a frame is 11 bits; without it a frame is 10 bits and
// parity_err stays 0.
// WORD_W must be greater than 8 so that a word spans at least two bytes.
module bench_td_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int WORD_W       = 21
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rx,
  output logic              word_valid,
  input  logic              word_ready,
  output logic [WORD_W-1:0] word,
  output logic              frame_err,
  output logic              overrun,
  output logic              parity_err
);

  localparam int BYTES  = (WORD_W + 7) / 8;
  localparam int ASM_W  = (BYTES - 1) * 8;
  localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W  = (BYTES > 2) ? $clog2(BYTES) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef BENCH_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } rxState_t;

  rxState_t          r_state;
  rxState_t          w_nextState;
  logic              r_rxMeta;
  logic              r_rxSync;
  logic [BAUD_W-1:0] r_baud;
  logic [2:0]        r_bitCnt;
  logic [7:0]        r_shift;
  logic [IDX_W-1:0]  r_byteIdx;
  logic [ASM_W-1:0]  r_assembly;
  logic              r_wordValid;
  logic [WORD_W-1:0] r_word;
  logic              r_frameErr;
  logic              r_overrun;

  logic w_baudClear;
  logic w_shiftBit;
  logic w_byteAccept;
  logic w_frameErrSet;
  logic w_parityErrSet;
  logic w_parityOk;
  logic w_wordDone;
  logic w_load;

`ifdef BENCH_RX_PARITY_EN
  logic r_parityBit;
  logic r_parityErr;
  logic w_sampleParity;
  assign w_parityOk = ((^r_shift) == r_parityBit);
`else
  assign w_parityOk = 1'b1;
`endif

  // Two-flop synchronizer for the asynchronous pin; idles high so reset looks like line idle.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rxMeta <= 1'b1;
      r_rxSync <= 1'b1;
    end else begin
      r_rxMeta <= rx;
      r_rxSync <= r_rxMeta;
    end
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_nextState;
  end

  // Next-state logic and per-cycle strobes; every sample point is the baud counter's terminal count.
  always_comb begin
    w_nextState    = r_state;
    w_baudClear    = 1'b0;
    w_shiftBit     = 1'b0;
    w_byteAccept   = 1'b0;
    w_frameErrSet  = 1'b0;
    w_parityErrSet = 1'b0;
`ifdef BENCH_RX_PARITY_EN
    w_sampleParity = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (!r_rxSync) begin
          w_nextState = S_START;
          w_baudClear = 1'b1;
        end
      end
      S_START: begin
        if (r_baud == BAUD_HALF) begin
          w_baudClear = 1'b1;
          w_nextState = r_rxSync ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (r_baud == BAUD_LAST) begin
          w_baudClear = 1'b1;
          w_shiftBit  = 1'b1;
          if (r_bitCnt == 3'd7) begin
`ifdef BENCH_RX_PARITY_EN
            w_nextState = S_PARITY;
`else
            w_nextState = S_STOP;
`endif
          end
        end
      end
`ifdef BENCH_RX_PARITY_EN
      S_PARITY: begin
        if (r_baud == BAUD_LAST) begin
          w_baudClear    = 1'b1;
          w_sampleParity = 1'b1;
          w_nextState    = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (r_baud == BAUD_LAST) begin
          w_baudClear = 1'b1;
          if (r_rxSync) begin
            w_nextState = S_IDLE;
            if (w_parityOk) w_byteAccept   = 1'b1;
            else            w_parityErrSet = 1'b1;
          end else begin
            w_frameErrSet = 1'b1;
            w_nextState   = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        if (r_rxSync) w_nextState = S_IDLE;
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  // Baud counter runs freely and is cleared at every state transition that starts a new interval.
  always_ff @(posedge clock) begin
    if (reset)            r_baud <= '0;
    else if (w_baudClear) r_baud <= '0;
    else                  r_baud <= r_baud + BAUD_W'(1);
  end

  // Data bit counter and LSB-first shift register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_bitCnt <= 3'd0;
      r_shift  <= 8'd0;
    end else if (r_state == S_IDLE) begin
      r_bitCnt <= 3'd0;
    end else if (w_shiftBit) begin
      r_bitCnt <= r_bitCnt + 3'd1;
      r_shift  <= {r_rxSync, r_shift[7:1]};
    end
  end

`ifdef BENCH_RX_PARITY_EN
  // Parity bit capture and error pulse reported at the stop-bit sample.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_parityBit <= 1'b0;
      r_parityErr <= 1'b0;
    end else begin
      if (w_sampleParity) r_parityBit <= r_rxSync;
      r_parityErr <= w_parityErrSet;
    end
  end
  assign parity_err = r_parityErr;
`else
  assign parity_err = 1'b0;
`endif

  // Byte index and partial word; any bad frame resynchronizes to byte 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_byteIdx  <= '0;
      r_assembly <= '0;
    end else if (w_frameErrSet || w_parityErrSet) begin
      r_byteIdx <= '0;
    end else if (w_byteAccept) begin
      if (r_byteIdx == IDX_LAST) begin
        r_byteIdx <= '0;
      end else begin
        r_byteIdx                    <= r_byteIdx + IDX_W'(1);
        r_assembly[8*r_byteIdx +: 8] <= r_shift;
      end
    end
  end

  assign w_wordDone = w_byteAccept && (r_byteIdx == IDX_LAST);
  assign w_load     = w_wordDone && (!r_wordValid || word_ready);

  // Holding buffer: refill allowed in the cycle it drains; otherwise a new word is an overrun.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wordValid <= 1'b0;
      r_word      <= '0;
      r_overrun   <= 1'b0;
      r_frameErr  <= 1'b0;
    end else begin
      r_overrun  <= w_wordDone && !w_load;
      r_frameErr <= w_frameErrSet;
      if (w_load) begin
        r_wordValid <= 1'b1;
        r_word      <= WORD_W'({r_shift, r_assembly});
      end else if (r_wordValid && word_ready) begin
        r_wordValid <= 1'b0;
      end
    end
  end

  assign word_valid = r_wordValid;
  assign word       = r_word;
  assign frame_err  = r_frameErr;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_bench_td_rx.sv
// Testbench for bench_td_rx: serial frames are driven on rx, a byte-level reference
// model predicts words and error pulses, and a monitor scores every handshake.
module tb_bench_td_rx;

  localparam int CPB    = 4;
  localparam int WORD_W = 21;
  localparam int BYTES  = 3;

  logic              clock = 1'b0;
  logic              reset;
  logic              rx;
  logic              word_valid;
  logic              word_ready;
  logic [WORD_W-1:0] word;
  logic              frame_err;
  logic              overrun;
  logic              parity_err;

  int checks = 0;
  int passes = 0;

  logic [31:0] expWords[$];
  int          modelIdx = 0;
  logic [31:0] modelPartial = 0;
  int          expFrameErr = 0, expParityErr = 0, expOverrun = 0;
  bit          holdMode = 0;
  int          modelHeld = 0;

  int obsFrameErr = 0, obsParityErr = 0, obsOverrun = 0;
  int validHighCycles = 0;
  int readyMode = 1;

  bench_td_rx #(.CLKS_PER_BIT(CPB), .WORD_W(WORD_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .rx         (rx),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .word       (word),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Reference model: a byte lands at slot idx of the word; bad frames resync to slot 0.
  task automatic modelFrame(input logic [7:0] b, input bit stopBit, input bit parBit);
    logic [31:0] w;
    if (!stopBit) begin
      expFrameErr++;
      modelIdx = 0;
      modelPartial = 0;
    end
`ifdef BENCH_RX_PARITY_EN
    else if (parBit != (^b)) begin
      expParityErr++;
      modelIdx = 0;
      modelPartial = 0;
    end
`endif
    else begin
      modelPartial = modelPartial | (32'(b) << (8 * modelIdx));
      modelIdx++;
      if (modelIdx == BYTES) begin
        w = modelPartial & ((32'd1 << WORD_W) - 32'd1);
        modelIdx = 0;
        modelPartial = 0;
        if (holdMode && modelHeld > 0) expOverrun++;
        else begin
          expWords.push_back(w);
          if (holdMode) modelHeld++;
        end
      end
    end
    if (parBit) begin end
  endtask

  task automatic sendBit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clock);
  endtask

  task automatic applyStimulus(input logic [7:0] b, input bit stopBit, input bit parBit);
    modelFrame(b, stopBit, parBit);
    sendBit(1'b0);
    for (int i = 0; i < 8; i++) sendBit(b[i]);
`ifdef BENCH_RX_PARITY_EN
    sendBit(parBit);
`endif
    sendBit(stopBit);
    if (!stopBit) sendBit(1'b1);
  endtask

  task automatic sendWord(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    applyStimulus(b0, 1'b1, ^b0);
    applyStimulus(b1, 1'b1, ^b1);
    applyStimulus(b2, 1'b1, ^b2);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clock);
  endtask

  task automatic checkCounters(input string tag);
    checkOutput({tag, "_frameErrCount"}, 32'(obsFrameErr), 32'(expFrameErr));
    checkOutput({tag, "_parityErrCount"}, 32'(obsParityErr), 32'(expParityErr));
    checkOutput({tag, "_overrunCount"}, 32'(obsOverrun), 32'(expOverrun));
    checkOutput({tag, "_pendingWords"}, 32'(expWords.size()), 32'd0);
  endtask

  // Consumer: ready low, high, or random per cycle.
  initial begin
    word_ready = 1'b0;
    forever begin
      @(negedge clock);
      case (readyMode)
        0:       word_ready = 1'b0;
        1:       word_ready = 1'b1;
        default: word_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: counts pulses and scores each handshake against the expected-word queue.
  initial begin
    forever begin
      @(negedge clock);
      #1;
      if (!reset) begin
        if (frame_err)  obsFrameErr++;
        if (parity_err) obsParityErr++;
        if (overrun)    obsOverrun++;
        if (word_valid) validHighCycles++;
        if (word_valid && word_ready) begin
          if (expWords.size() == 0) begin
            checks++;
            $display("[TB] FAIL unexpectedWord: got 0x%0h, expected no word", word);
          end else begin
            checkOutput("word", 32'(word), expWords.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [7:0] b;
    bit         stopBit;
    bit         parBit;

    rx = 1'b1;
    reset = 1'b1;
    readyMode = 1;
    repeat (3) @(negedge clock);
    checkOutput("resetValid", 32'(word_valid), 32'd0);
    checkOutput("resetWord", 32'(word), 32'd0);
    checkOutput("resetFrameErr", 32'(frame_err), 32'd0);
    checkOutput("resetOverrun", 32'(overrun), 32'd0);
    checkOutput("resetParityErr", 32'(parity_err), 32'd0);
    reset = 1'b0;
    idle(8);
    checkOutput("idleValid", 32'(word_valid), 32'd0);

    // Basic word with ready held high
    validHighCycles = 0;
    sendWord(8'h55, 8'hAA, 8'h1F);
    idle(3 * CPB);
    checkOutput("basicValidCycles", 32'(validHighCycles), 32'd1);
    checkCounters("basic");

    // Top byte bits above WORD_W are discarded
    sendWord(8'hFF, 8'hFF, 8'hFF);
    idle(3 * CPB);
    checkCounters("truncate");

    // Overrun while the consumer stalls
    readyMode = 0;
    holdMode = 1;
    modelHeld = 0;
    idle(2);
    sendWord(8'h01, 8'h02, 8'h03);
    sendWord(8'h04, 8'h05, 8'h06);
    idle(3 * CPB);
    checkOutput("holdValid", 32'(word_valid), 32'd1);
    checkOutput("holdWord", 32'(word), 32'h030201);
    checkOutput("holdOverrun", 32'(obsOverrun), 32'(expOverrun));
    holdMode = 0;
    modelHeld = 0;
    readyMode = 1;
    idle(4);
    checkOutput("drainValid", 32'(word_valid), 32'd0);
    checkCounters("overrun");

    // Framing error resynchronizes the word
    applyStimulus(8'h11, 1'b0, ^8'h11);
    sendWord(8'h01, 8'h02, 8'h03);
    idle(3 * CPB);
    checkCounters("frameErr");

    // One-cycle glitch is rejected
    rx = 1'b0;
    @(negedge clock);
    idle(3 * CPB);
    sendWord(8'h0A, 8'h0B, 8'h0C);
    idle(3 * CPB);
    checkCounters("glitch");

    // Reset mid-word and mid-frame discards the partial word
    applyStimulus(8'h77, 1'b1, ^8'h77);
    rx = 1'b0;
    repeat (6) @(negedge clock);
    rx = 1'b1;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    modelIdx = 0;
    modelPartial = 0;
    checkOutput("midResetValid", 32'(word_valid), 32'd0);
    idle(4);
    sendWord(8'h21, 8'h43, 8'h65);
    idle(3 * CPB);
    checkCounters("midReset");

`ifdef BENCH_RX_PARITY_EN
    // Wrong parity drops the byte; correct parity accepts it
    applyStimulus(8'h03, 1'b1, 1'b1);
    applyStimulus(8'h03, 1'b1, 1'b0);
    applyStimulus(8'h02, 1'b1, 1'b1);
    applyStimulus(8'h01, 1'b1, 1'b1);
    idle(3 * CPB);
    checkCounters("parity");
`endif

    // Randomized traffic with random consumer backpressure
    readyMode = 2;
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        rx = 1'b0;
        @(negedge clock);
        idle(2 * CPB);
      end
      b = 8'($urandom_range(0, 255));
      stopBit = ($urandom_range(0, 7) != 0);
      parBit = ^b;
`ifdef BENCH_RX_PARITY_EN
      if (stopBit && $urandom_range(0, 7) == 0) parBit = ~parBit;
`endif
      applyStimulus(b, stopBit, parBit);
      idle($urandom_range(0, CPB));
    end
    readyMode = 1;
    idle(20 * CPB);
    checkCounters("random");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
